// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
// MATMUL_SAT_EN selects saturating (defined) or truncating (undefined) result reduction.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Exact accumulator width for a sum of N products of two DW-bit values.
    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Row-major flat packing with element (0,0) in the MSBs.
    function automatic int elem_lsb(input int i, input int j, input int n, input int w);
        return (n * n - 1 - (i * n + j)) * w;
    endfunction

    // Caller keeps the low rw bits; rw must stay below 64.
    function automatic logic [63:0] reduce(input logic [63:0] x, input int rw);
        logic [63:0] max;
        max = (64'd1 << rw) - 64'd1;
`ifdef MATMUL_SAT_EN
        return (x > max) ? max : x;
`else
        return x & max;
`endif
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit: registered accumulator plus a combinational acc + a*b tap.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] sum
);
    logic [ACC_W-1:0] acc;
    logic [2*DW-1:0]  prod;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign sum  = acc + ACC_W'(prod);

    // clr wins over en so the last product of an element is dropped, not carried.
    always_ff @(posedge clk) begin
        if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN unsigned matrix multiplier (Res = A*B) built around one MAC, N^3 cycles per product.
// Result reduction is saturating when MATMUL_SAT_EN is defined, truncating otherwise.
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int RW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] a,
    input  logic [N*N*DW-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*RW-1:0] res
);
    localparam int              ACC_W = acc_w(N, DW);
    localparam int              IW    = $clog2(N);
    localparam logic [IW-1:0]   LAST  = IW'(N - 1);

    state_t            state;
    logic [N*N*DW-1:0] a_q, b_q;
    logic [IW-1:0]     i, j, k;
    logic [DW-1:0]     op_a, op_b;
    logic [ACC_W-1:0]  sum;
    logic [RW-1:0]     red;
    logic              accept, calc, elem_end, mac_clr;

    // in_ready is only ever high in IDLE, so this is the accept handshake.
    assign accept   = in_valid & in_ready;
    assign calc     = (state == CALC);
    assign elem_end = calc && (k == LAST);
    assign mac_clr  = rst | accept | elem_end;

    assign op_a = a_q[elem_lsb(int'(i), int'(k), N, DW) +: DW];
    assign op_b = b_q[elem_lsb(int'(k), int'(j), N, DW) +: DW];
    assign red  = RW'(reduce(64'(sum), RW));

    matmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .clr (mac_clr),
        .en  (calc),
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (k == LAST) begin
                        res[elem_lsb(int'(i), int'(j), N, RW) +: RW] <= red;
                        k <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) begin
                                i     <= '0;
                                state <= DONE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle raises out_valid; it then holds until consumed.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Randomized self-checking bench for matrix_mult_seq at N=2 and N=3 against an arithmetic reference model.
module tb_matrix_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv2 = 1'b0, ir2, ov2, or2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0, r2;
    logic        iv3 = 1'b0, ir3, ov3, or3 = 1'b0;
    logic [71:0] a3 = '0, b3 = '0, r3;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    matrix_mult_seq #(.N(2), .DW(8), .RW(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .res(r2)
    );

    matrix_mult_seq #(.N(3), .DW(8), .RW(8)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
        .out_valid(ov3), .out_ready(or3), .res(r3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int elem(input logic [127:0] x, input int n, input int i, input int j);
        logic [127:0] v;
        v = (x >> ((n * n - 1 - (i * n + j)) * 8)) & 128'hFF;
        return int'(v[7:0]);
    endfunction

    function automatic logic [127:0] model(input int n, input logic [127:0] av, input logic [127:0] bv);
        logic [127:0] r;
        longint       s;
        r = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(elem(av, n, i, k)) * longint'(elem(bv, n, k, j));
`ifdef MATMUL_SAT_EN
                if (s > 255) s = 255;
`else
                s = s % 256;
`endif
                r |= (128'(s) << ((n * n - 1 - (i * n + j)) * 8));
            end
        return r;
    endfunction

    function automatic logic rdy(input int n);
        return (n == 2) ? ir2 : ir3;
    endfunction

    function automatic logic vld(input int n);
        return (n == 2) ? ov2 : ov3;
    endfunction

    function automatic logic [127:0] rsl(input int n);
        return (n == 2) ? 128'(r2) : 128'(r3);
    endfunction

    task automatic set_in(input int n, input logic v, input logic [127:0] av, input logic [127:0] bv);
        if (n == 2) begin iv2 = v; a2 = av[31:0]; b2 = bv[31:0]; end
        else        begin iv3 = v; a3 = av[71:0]; b3 = bv[71:0]; end
    endtask

    task automatic set_ordy(input int n, input logic v);
        if (n == 2) or2 = v; else or3 = v;
    endtask

    function automatic logic [127:0] rnd_mat(input int n);
        logic [127:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        return m & ((128'd1 << (n * n * 8)) - 128'd1);
    endfunction

    // One full transaction: accept, latency check, optional DONE stall, output handshake.
    task automatic run(input int n, input logic [127:0] av, input logic [127:0] bv,
                       input logic [127:0] exp, input int hold, input string tag);
        int lat = 0;
        int w   = 0;
        @(negedge clk);
        while (!rdy(n) && w < 50) begin @(negedge clk); w++; end
        chk({tag, " in_ready idle"}, 128'(rdy(n)), 128'd1);
        set_in(n, 1'b1, av, bv);
        @(posedge clk);
        #1 set_in(n, 1'b0, rnd_mat(n), rnd_mat(n));
        do begin @(posedge clk); lat++; #1; end while (!vld(n) && lat < 100);
        chk({tag, " latency"}, 128'(lat), 128'(n * n * n + 1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold res"}, rsl(n), exp);
            chk({tag, " hold out_valid"}, 128'(vld(n)), 128'd1);
            chk({tag, " hold in_ready"}, 128'(rdy(n)), 128'd0);
        end
        @(negedge clk);
        chk({tag, " res"}, rsl(n), exp);
        set_ordy(n, 1'b1);
        @(posedge clk);
        #1 set_ordy(n, 1'b0);
        chk({tag, " out_valid after hs"}, 128'(vld(n)), 128'd0);
        chk({tag, " in_ready after hs"}, 128'(rdy(n)), 128'd1);
    endtask

    initial begin
        logic [127:0] sa, sb, ta, tb, exp_sat;
        int           cyc, hs, acc, hs_cyc0, acc_cyc1, hi_cnt;
        logic         took;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready2", 128'(ir2), 128'd1);
        chk("reset out_valid2", 128'(ov2), 128'd0);
        chk("reset res2", 128'(r2), 128'd0);
        chk("reset in_ready3", 128'(ir3), 128'd1);
        chk("reset res3", 128'(r3), 128'd0);

        run(2, 128'h01020304, 128'h05060708, 128'h13162B32, 0, "basic2x2");

`ifdef MATMUL_SAT_EN
        exp_sat = 128'hFFFFFFFF;
`else
        exp_sat = 128'h02020202;
`endif
        run(2, 128'hFFFFFFFF, 128'hFFFFFFFF, exp_sat, 0, "allff");
        run(2, 128'h0A0B0C0D, 128'h01020304, model(2, 128'h0A0B0C0D, 128'h01020304), 5, "stall5");

        // Reset in the 4th CALC cycle: the earlier nonzero result must be wiped and nothing emitted.
        @(negedge clk);
        set_in(2, 1'b1, 128'h11223344, 128'h55667788);
        @(posedge clk);
        #1 set_in(2, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst out_valid", 128'(ov2), 128'd0);
        chk("midrst res", 128'(r2), 128'd0);
        chk("midrst in_ready", 128'(ir2), 128'd1);
        hi_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ov2) hi_cnt++;
        end
        chk("midrst no output", 128'(hi_cnt), 128'd0);

        run(3, 128'h010000000100000001, 128'h010203040506070809, 128'h010203040506070809, 0, "ident3");

        for (int t = 0; t < 6; t++) begin
            sa = rnd_mat(2); sb = rnd_mat(2);
            run(2, sa, sb, model(2, sa, sb), $urandom_range(0, 3), "rand2");
        end
        for (int t = 0; t < 3; t++) begin
            sa = rnd_mat(3); sb = rnd_mat(3);
            run(3, sa, sb, model(3, sa, sb), $urandom_range(0, 2), "rand3");
        end

        // Back-to-back: in_valid and out_ready stay high across two operand sets.
        sa = rnd_mat(2); sb = rnd_mat(2);
        ta = rnd_mat(2); tb = rnd_mat(2);
        @(negedge clk);
        set_ordy(2, 1'b1);
        set_in(2, 1'b1, sa, sb);
        cyc = 0; hs = 0; acc = 0; hs_cyc0 = -10; acc_cyc1 = -20;
        while (hs < 2 && cyc < 200) begin
            took = 1'b0;
            if (ir2 && iv2) begin
                if (acc == 1) acc_cyc1 = cyc;
                acc++;
                took = 1'b1;
            end
            if (ov2 && or2) begin
                chk("b2b res", 128'(r2), (hs == 0) ? model(2, sa, sb) : model(2, ta, tb));
                if (hs == 0) hs_cyc0 = cyc;
                hs++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                if (acc == 1) set_in(2, 1'b1, ta, tb);
                else          set_in(2, 1'b0, '0, '0);
            end
            @(negedge clk);
            cyc++;
        end
        set_ordy(2, 1'b0);
        set_in(2, 1'b0, '0, '0);
        chk("b2b handshakes", 128'(hs), 128'd2);
        chk("b2b accepts", 128'(acc), 128'd2);
        chk("b2b second accept timing", 128'(acc_cyc1), 128'(hs_cyc0 + 1));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
